// File: rtl/regfile_sb.sv
// regfile_sb: multi-write register file with a per-register busy scoreboard.
// Two bypassed operand read ports, ALU and load write-back ports, one raw debug read port.
module regfile_sb #(
  parameter int unsigned  WIDTH    = 32,
  parameter int unsigned  DEPTH    = 32,
  parameter bit           ZERO_REG = 1'b1,
  parameter bit           BYPASS   = 1'b1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  output logic             busy0,
  output logic             busy1,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1,
  input  logic             iss,
  input  logic [AW-1:0]    iss_wa,
  input  logic             flush,
  input  logic [AW-1:0]    dbg_ra,
  output logic [WIDTH-1:0] dbg_rd
);

  logic [WIDTH-1:0]         r_mem [DEPTH];
  logic [DEPTH-1:0]         r_busy;
  logic [DEPTH-1:0]         w_busy_nxt;
  logic                     w_we0;
  logic                     w_we1;
  logic [1:0][AW-1:0]       w_ra;
  logic [1:0][WIDTH-1:0]    w_rd;
  logic [1:0]               w_busy;

  // Writes to the hard-wired zero register are dropped here, once for all consumers.
  assign w_we0 = we0 && !(ZERO_REG && (wa0 == '0));
  assign w_we1 = we1 && !(ZERO_REG && (wa1 == '0));

  // Storage; port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_we0) r_mem[wa0] <= wd0;
      if (w_we1) r_mem[wa1] <= wd1;
    end
  end

  // Scoreboard next state: later assignments carry higher priority.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((w_we0 && (wa0 == AW'(i))) || (w_we1 && (wa1 == AW'(i)))) begin
        w_busy_nxt[i] = 1'b0;
      end
      if (flush) begin
        w_busy_nxt[i] = 1'b0;
      end
      if (iss && (iss_wa == AW'(i)) && !(ZERO_REG && (i == 0))) begin
        w_busy_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign w_ra = {ra1, ra0};

  // Per read port: zero-register override, then port 1 bypass, port 0 bypass, storage.
  for (genvar k = 0; k < 2; k++) begin : g_rd
    logic             w_zero;
    logic             w_hit0;
    logic             w_hit1;
    logic [WIDTH-1:0] w_data;

    assign w_zero = ZERO_REG && (w_ra[k] == '0);
    assign w_hit0 = BYPASS && we0 && (wa0 == w_ra[k]) && !w_zero;
    assign w_hit1 = BYPASS && we1 && (wa1 == w_ra[k]) && !w_zero;

    always_comb begin
      w_data = r_mem[w_ra[k]];
      if (w_zero) begin
        w_data = '0;
      end else if (w_hit1) begin
        w_data = wd1;
      end else if (w_hit0) begin
        w_data = wd0;
      end
    end

    assign w_rd[k]   = w_data;
    assign w_busy[k] = !w_zero && r_busy[w_ra[k]] && !w_hit0 && !w_hit1;
  end

  assign rd0    = w_rd[0];
  assign rd1    = w_rd[1];
  assign busy0  = w_busy[0];
  assign busy1  = w_busy[1];
  assign dbg_rd = r_mem[dbg_ra];

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: random stimulus against a register-file model, a reset sweep, and a directed vector table.
module tb_regfile_sb;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    ra0, ra1, wa0, wa1, iss_wa, dbg_ra;
  logic [WIDTH-1:0] rd0, rd1, wd0, wd1, dbg_rd;
  logic             busy0, busy1, we0, we1, iss, flush;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] m_mem  [DEPTH];
  bit               m_busy [DEPTH];

  typedef struct {
    logic             rst;
    logic             we0;
    logic [AW-1:0]    wa0;
    logic [WIDTH-1:0] wd0;
    logic             we1;
    logic [AW-1:0]    wa1;
    logic [WIDTH-1:0] wd1;
    logic             iss;
    logic [AW-1:0]    iss_wa;
    logic             flush;
    logic [AW-1:0]    ra0;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    dbg_ra;
    logic [WIDTH-1:0] e_rd0;
    logic [WIDTH-1:0] e_rd1;
    logic             e_b0;
    logic             e_b1;
    logic [WIDTH-1:0] e_dbg;
  } vec_t;

  vec_t vecs [20];

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1), .busy0(busy0), .busy1(busy1),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss(iss), .iss_wa(iss_wa), .flush(flush), .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; we0 = 1'b0; wa0 = '0; wd0 = '0; we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss = 1'b0; iss_wa = '0; flush = 1'b0;
  endtask

  // Model: register 0 is constant zero; a same-cycle write is visible to operand reads.
  function automatic logic [WIDTH-1:0] m_rd(input logic [AW-1:0] ra);
    if (ra == '0) return '0;
    if (we1 && wa1 == ra) return wd1;
    if (we0 && wa0 == ra) return wd0;
    return m_mem[ra];
  endfunction

  function automatic logic m_bsy(input logic [AW-1:0] ra);
    if (ra == '0) return 1'b0;
    if ((we0 && wa0 == ra) || (we1 && wa1 == ra)) return 1'b0;
    return m_busy[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Clock edge: writes land, written registers retire, flush clears, a new issue wins over both.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      end else begin
        if (we0) m_busy[wa0] = 1'b0;
        if (we1) m_busy[wa1] = 1'b0;
      end
      if (we0 && wa0 != '0) m_mem[wa0] = wd0;
      if (we1 && wa1 != '0) m_mem[wa1] = wd1;
      if (iss && iss_wa != '0) m_busy[iss_wa] = 1'b1;
      m_busy[0] = 1'b0;
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0; we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
    iss = v.iss; iss_wa = v.iss_wa; flush = v.flush;
    ra0 = v.ra0; ra1 = v.ra1; dbg_ra = v.dbg_ra;
    #1;
    chk($sformatf("vec%0d.rd0", idx), rd0, v.e_rd0);
    chk($sformatf("vec%0d.rd1", idx), rd1, v.e_rd1);
    chk($sformatf("vec%0d.busy0", idx), 32'(busy0), 32'(v.e_b0));
    chk($sformatf("vec%0d.busy1", idx), 32'(busy1), 32'(v.e_b1));
    chk($sformatf("vec%0d.dbg_rd", idx), dbg_rd, v.e_dbg);
  endtask

  initial begin
    // rst we0 wa0 wd0 we1 wa1 wd1 iss iss_wa flush ra0 ra1 dbg_ra | rd0 rd1 b0 b1 dbg
    vecs[0]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 5'd5,
                 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6, 5'd5,
                 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 1'b0, 5'd7, 5'd5, 5'd7,
                 32'h2, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 5'd7,
                 32'h2, 32'h0, 1'b0, 1'b0, 32'h2};
    vecs[4]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 5'd3,
                 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 5'd3,
                 32'h0, 32'h0, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4, 5'd3,
                 32'h33, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4, 5'd3,
                 32'h33, 32'h0, 1'b0, 1'b0, 32'h33};
    vecs[10] = '{1'b0, 1'b1, 5'd3, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 5'd3,
                 32'h44, 32'h44, 1'b0, 1'b0, 32'h33};
    vecs[11] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 5'd3,
                 32'h44, 32'h44, 1'b1, 1'b1, 32'h44};
    vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 5'd3, 5'd2, 5'd3,
                 32'h44, 32'h0, 1'b1, 1'b0, 32'h44};
    vecs[13] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd2, 5'd3,
                 32'h44, 32'h0, 1'b1, 1'b1, 32'h44};
    vecs[14] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd4, 5'd2, 5'd3,
                 32'h0, 32'h0, 1'b1, 1'b1, 32'h44};
    vecs[15] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd9, 5'd2, 5'd3,
                 32'h0, 32'h0, 1'b1, 1'b1, 32'h44};
    vecs[16] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd4, 5'd3,
                 32'h0, 32'h0, 1'b0, 1'b1, 32'h44};
    vecs[17] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd3, 5'd3,
                 32'h0, 32'h44, 1'b0, 1'b0, 32'h44};
    vecs[18] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd4, 5'd9, 5'd3,
                 32'h0, 32'h0, 1'b1, 1'b0, 32'h44};
    vecs[19] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd5, 5'd3,
                 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};

    idle_inputs();
    ra0 = '0; ra1 = '0; dbg_ra = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();

    // Random traffic checked against the model before every edge.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 63) == 0);
      we0    = 1'($urandom_range(0, 1));
      wa0    = rnd_addr();
      wd0    = $urandom();
      we1    = ($urandom_range(0, 2) == 0);
      wa1    = rnd_addr();
      wd1    = $urandom();
      iss    = ($urandom_range(0, 2) == 0);
      iss_wa = rnd_addr();
      flush  = ($urandom_range(0, 15) == 0);
      ra0    = rnd_addr();
      ra1    = rnd_addr();
      dbg_ra = rnd_addr();
      #1;
      chk("rnd.rd0", rd0, m_rd(ra0));
      chk("rnd.rd1", rd1, m_rd(ra1));
      chk("rnd.busy0", 32'(busy0), 32'(m_bsy(ra0)));
      chk("rnd.busy1", 32'(busy1), 32'(m_bsy(ra1)));
      chk("rnd.dbg_rd", dbg_rd, m_mem[dbg_ra]);
      model_step();
    end

    // Reset after random writes, then sweep every register.
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    for (int r = 0; r < DEPTH; r++) begin
      @(negedge clk);
      idle_inputs();
      ra0    = AW'(r);
      ra1    = AW'(DEPTH - 1 - r);
      dbg_ra = AW'(r);
      #1;
      chk($sformatf("rst.rd0[%0d]", r), rd0, '0);
      chk($sformatf("rst.rd1[%0d]", DEPTH - 1 - r), rd1, '0);
      chk($sformatf("rst.busy0[%0d]", r), 32'(busy0), 32'h0);
      chk($sformatf("rst.busy1[%0d]", DEPTH - 1 - r), 32'(busy1), 32'h0);
      chk($sformatf("rst.dbg_rd[%0d]", r), dbg_rd, '0);
    end

    // Directed sequences from a reset state.
    for (int i = 0; i < 20; i++) begin
      apply(vecs[i], i);
    end

    @(negedge clk);
    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
